// File: rtl/jk_bank_controller.sv
// Command-queued sequencer for a bank of JK flip-flop cells.
// Each queued {index, op} command drives one cell for a single edge, then GAP idle cycles follow.
module jk_bank_controller #(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int GAP   = 1,
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [IW-1:0] cmd_idx,
    input  logic [1:0]    cmd_op,
    output logic [N-1:0]  q,
    output logic [N-1:0]  qbar,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = 1 << IW;

    typedef enum logic [1:0] {IDLE, APPLY, WAIT} state_t;

    state_t        state_q, state_d;
    logic [IW+1:0] fifoMem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    op_q, op_d;
    logic [2:0]    gapCnt_q, gapCnt_d;
    logic [N-1:0]  cell_q, cell_d;
    logic          done_q, done_d, err_q, err_d;
    logic          push, pop, inRange;
    logic [SW-1:0] selOneHot;
    logic [N-1:0]  jVec, kVec;

    // A full FIFO never accepts, even if it is popping on the same edge.
    assign cmd_ready = ~rst & (count_q != (AW+1)'(DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);

    assign q    = cell_q;
    assign qbar = ~cell_q;
    assign busy = (state_q != IDLE) || (count_q != '0);
    assign done = done_q;
    assign err  = err_q;

    always_comb begin
        selOneHot        = '0;
        selOneHot[idx_q] = 1'b1;
        // Any decoded bit at or beyond N marks an index with no cell behind it.
        inRange = ~|(selOneHot >> N);
        jVec    = '0;
        kVec    = '0;
        if (state_q == APPLY) begin
            jVec = selOneHot[N-1:0] & {N{op_q[1]}};
            kVec = selOneHot[N-1:0] & {N{op_q[0]}};
        end
        cell_d = (jVec & ~cell_q) | (~kVec & cell_q);
    end

    always_comb begin
        wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        gapCnt_d = gapCnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    idx_d   = fifoMem_q[rdPtr_q][IW+1:2];
                    op_d    = fifoMem_q[rdPtr_q][1:0];
                    state_d = APPLY;
                end
            end
            APPLY: begin
                done_d   = inRange;
                err_d    = ~inRange;
                gapCnt_d = '0;
                state_d  = (GAP == 0) ? IDLE : WAIT;
            end
            WAIT: begin
                gapCnt_d = gapCnt_q + 3'd1;
                if (gapCnt_q == 3'(GAP - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {cmd_idx, cmd_op};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            op_q     <= '0;
            gapCnt_q <= '0;
            cell_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            gapCnt_q <= gapCnt_d;
            cell_q   <= cell_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_jk_bank_controller.sv
// Scoreboard bench for jk_bank_controller: accepted commands queue their expected outcome,
// and a negedge monitor pops and compares on every done/err pulse.
module tb_jk_bank_controller;
    localparam int N     = 3;
    localparam int DEPTH = 4;
    localparam int GAP   = 1;
    localparam int IW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IW-1:0] cmd_idx;
    logic [1:0]    cmd_op;
    logic [N-1:0]  q, qbar;
    logic          busy, done, err;

    typedef struct packed {
        logic         isErr;
        logic [N-1:0] qExp;
    } exp_t;

    exp_t         expQ[$];
    logic [N-1:0] modelQ = '0;
    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int lastPulse = -1;
    int doneCnt = 0;
    int errCnt = 0;
    bit sawNotReady = 0;

    jk_bank_controller #(.N(N), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_idx(cmd_idx), .cmd_op(cmd_op), .q(q), .qbar(qbar),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference semantics of a JK op on a plain bit vector.
    function automatic logic [N-1:0] applyOp(input logic [N-1:0] cur, input int idx, input logic [1:0] op);
        logic [N-1:0] r;
        r = cur;
        case (op)
            2'b01:   r[idx] = 1'b0;
            2'b10:   r[idx] = 1'b1;
            2'b11:   r[idx] = ~r[idx];
            default: r[idx] = r[idx];
        endcase
        return r;
    endfunction

    // Monitor first consumes pulses, then records the transfer that the next posedge will take.
    always @(negedge clk) begin : monitor
        exp_t e;
        checkOutput("qbar complement", qbar ^ q, {N{1'b1}});
        if (done || err) begin
            if (done) doneCnt++;
            if (err) errCnt++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected pulse", {30'd0, done, err}, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("pulse kind", {30'd0, done, err}, e.isErr ? 32'd1 : 32'd2);
                checkOutput("q after op", q, e.qExp);
                if (lastPulse >= 0) begin
                    checkOutput("pulse spacing", (cycle - lastPulse) >= (2 + GAP), 1);
                end
                lastPulse = cycle;
            end
        end
        if (rst) begin
            expQ.delete();
            modelQ    = '0;
            lastPulse = -1;
            checkOutput("ready low in reset", cmd_ready, 0);
        end else if (cmd_valid && cmd_ready) begin
            if (int'(cmd_idx) >= N) begin
                expQ.push_back({1'b1, modelQ});
            end else begin
                modelQ = applyOp(modelQ, int'(cmd_idx), cmd_op);
                expQ.push_back({1'b0, modelQ});
            end
        end
        if (!rst && !cmd_ready) sawNotReady = 1;
    end

    task automatic applyStimulus(input int idx, input logic [1:0] op);
        bit accepted;
        accepted  = 0;
        cmd_valid = 1'b1;
        cmd_idx   = IW'(idx);
        cmd_op    = op;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            if (cmd_ready) accepted = 1;
            @(posedge clk);
            #1;
        end
        checkOutput("command accepted", accepted, 1);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (expQ.size() == 0 && !busy) break;
        end
        checkOutput("scoreboard drained", expQ.size(), 0);
        checkOutput("busy after drain", busy, 0);
    endtask

    task automatic pulseReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        int d0, e0;
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_idx   = '0;
        cmd_op    = 2'b10;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("reset ready", cmd_ready, 0);
        end
        checkOutput("reset q", q, 0);
        checkOutput("reset qbar", qbar, 3'b111);
        checkOutput("reset done", done, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset busy", busy, 0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("nothing enqueued in reset", busy, 0);

        // Single set then reset with exact latency.
        applyStimulus(2, 2'b10);
        cmd_valid = 1'b0;
        checkOutput("busy after accept", busy, 1);
        @(posedge clk); #1;
        checkOutput("q before apply edge", q, 0);
        checkOutput("done before apply edge", done, 0);
        @(posedge clk); #1;
        checkOutput("q two edges after accept", q, 3'b100);
        checkOutput("done after apply", done, 1);
        @(posedge clk); #1;
        checkOutput("done one cycle", done, 0);
        waitIdle();
        applyStimulus(2, 2'b01);
        cmd_valid = 1'b0;
        waitIdle();
        checkOutput("q after reset op", q, 0);

        // Toggle, toggle, hold on cell 1.
        d0 = doneCnt;
        applyStimulus(1, 2'b11);
        applyStimulus(1, 2'b11);
        applyStimulus(1, 2'b00);
        cmd_valid = 1'b0;
        waitIdle();
        checkOutput("toggle done count", doneCnt - d0, 3);
        checkOutput("q after toggles", q, 0);

        // Hold valid for 8 cycles to fill the FIFO.
        sawNotReady = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1'b1;
            cmd_idx   = IW'(i % N);
            cmd_op    = (i % 2 == 0) ? 2'b10 : 2'b01;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        checkOutput("ready dropped when full", sawNotReady, 1);
        waitIdle();

        // Out-of-range index followed by a normal set.
        pulseReset(2);
        d0 = doneCnt;
        e0 = errCnt;
        applyStimulus(3, 2'b10);
        applyStimulus(0, 2'b10);
        cmd_valid = 1'b0;
        waitIdle();
        checkOutput("bad index err count", errCnt - e0, 1);
        checkOutput("bad index done count", doneCnt - d0, 1);
        checkOutput("q after bad index", q, 3'b001);

        // Reset while the first real command is in APPLY, two more queued.
        applyStimulus(0, 2'b00);
        applyStimulus(1, 2'b10);
        applyStimulus(2, 2'b10);
        applyStimulus(2, 2'b01);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        pulseReset(2);
        checkOutput("mid reset q", q, 0);
        checkOutput("mid reset busy", busy, 0);
        d0 = doneCnt;
        e0 = errCnt;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("no done after mid reset", doneCnt - d0, 0);
        checkOutput("no err after mid reset", errCnt - e0, 0);
        checkOutput("q stays clear", q, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_idx   = IW'($urandom_range(0, 3));
            cmd_op    = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        waitIdle();
        checkOutput("final q vs model", q, modelQ);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
